mc_controller: RTL and testbench
================================

# mc_controller

Main control FSM for the multicycle MIPS datapath. It sequences instruction fetch, decode, execute, memory and writeback over several cycles. It stalls on a memory ready handshake and drives every datapath mux select and write enable. It drives the 3-bit ALU-op code consumed by the ALU decoder; for R-type execution it asserts `alufunct` so the ALU decoder derives the operation from the funct field.

## Interface
- No parameters.
- `clk` in 1: single clock; all state changes on rising edge.
- `reset` in 1: synchronous, active-high.
- `op` in 6: opcode from the instruction register; stable from the cycle after FETCH completes.
- `zero` in 1: ALU condition flag; 1 means the beq/blez condition is met.
- `memready` in 1: memory access completes this cycle.
- `pcen` out 1: PC write enable, equal to `pcwrite | (branch & zero)`.
- `iord` out 1: memory address select (0 = PC, 1 = ALUOut).
- `memwrite` out 1: memory write strobe.
- `irwrite` out 1: instruction register load.
- `regdst` out 1: register destination select (1 = rd, 0 = rt).
- `memtoreg` out 1: register write data select (1 = memory data, 0 = ALUOut).
- `regwrite` out 1: register file write enable.
- `alusrca` out 1: ALU A select (0 = PC, 1 = register A).
- `alusrcb` out 2: ALU B select (00 = B, 01 = 4, 10 = extended immediate, 11 = extended immediate shifted left 2).
- `zeroext` out 1: immediate is zero-extended rather than sign-extended.
- `pcsrc` out 2: next-PC select (00 = ALU result, 01 = ALUOut, 10 = jump target).
- `aluop` out 3: ALU-op code.
  - 000 add, 001 sub (beq), 010 blez, 011 or, 100 lui, 101 xor, 110 slt (slti), 111 and.
- `alufunct` out 1: ALU operation comes from the funct field.
- `illegal` out 1: one-cycle pulse flagging an unsupported opcode.
- `state` out 4: current state, for debug.

## Operation
- States and 4-bit encodings:
  - FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, RTYPEEX=6, ALUWB=7, BEQEX=8, IMMEX=9, IMMWB=10, JEX=11, BLEZEX=12.
  - Codes 13–15 are unreachable and return to FETCH.
- All outputs are 0 unless listed for the state below.
- FETCH:
  - Drives `alusrcb`=01, `aluop`=000.
  - `irwrite` = `pcwrite` = `memready`.
  - Stays in FETCH while `memready`=0; goes to DECODE when `memready`=1.
- DECODE:
  - Drives `alusrcb`=11, `aluop`=000 (branch target into ALUOut).
  - Next state by `op`:
    - 100011 (lw) or 101011 (sw) → MEMADR.
    - 000000 (R-type) → RTYPEEX.
    - 000100 (beq) → BEQEX.
    - 000110 (blez) → BLEZEX.
    - 000010 (j) → JEX.
    - 001000 (addi), 001010 (slti), 001100 (andi), 001101 (ori), 001110 (xori), 001111 (lui) → IMMEX.
    - Any other opcode → FETCH with `illegal`=1.
- MEMADR:
  - Drives `alusrca`=1, `alusrcb`=10, `aluop`=000.
  - Goes to MEMRD for lw, MEMWR for sw.
- MEMRD:
  - Drives `iord`=1.
  - Waits for `memready`, then goes to MEMWB.
- MEMWB: drives `memtoreg`=1, `regwrite`=1 (`regdst`=0), then goes to FETCH.
- MEMWR:
  - Drives `iord`=1, `memwrite`=1, held while waiting.
  - Goes to FETCH on `memready`.
- RTYPEEX: drives `alusrca`=1, `alusrcb`=00, `alufunct`=1, `aluop`=000, then goes to ALUWB.
- ALUWB: drives `regdst`=1, `regwrite`=1, then goes to FETCH.
- BEQEX:
  - Drives `alusrca`=1, `alusrcb`=00, `aluop`=001, `pcsrc`=01, internal `branch`=1.
  - Goes to FETCH.
- BLEZEX: same as BEQEX with `aluop`=010.
- IMMEX:
  - Drives `alusrca`=1, `alusrcb`=10.
  - `aluop` by opcode: addi 000, slti 110, andi 111, ori 011, xori 101, lui 100.
  - `zeroext`=1 for andi, ori, xori.
  - Goes to IMMWB.
- IMMWB: drives `regwrite`=1 (`regdst`=0, `memtoreg`=0), then goes to FETCH.
- JEX: drives `pcsrc`=10, `pcwrite`=1, then goes to FETCH.

## Timing
- Reset:
  - In a cycle with `reset`=1, all write enables are forced to 0: `pcen`, `memwrite`, `irwrite`, `regwrite`.
  - The next state is FETCH, so `state`=0 in the first cycle after reset.
  - Reset has priority in every state, including mid-stall.
- Outputs:
  - All outputs are Moore decodes of `state`.
  - Exceptions: `irwrite`/`pcwrite` in FETCH (gated by `memready`) and `pcen` (gated by `zero`).
- Cycles per instruction with `memready` tied to 1:
  - lw 5; sw, R-type, immediate ops 4; beq, blez, j 3; illegal 2.
- Each cycle of `memready`=0 in FETCH, MEMRD or MEMWR adds exactly one cycle.
- `memwrite` stays high for the whole MEMWR dwell; `memready` is ignored in every other state.

## Test plan
- Reset with `memready`=1, then a lw (op=100011) → states 0,1,2,3,4,0; `regwrite`=1 and `memtoreg`=1 only in state 4; `irwrite`=1 only in the first cycle.
- sw with `memready` low for 3 cycles in MEMWR → `memwrite`=1 for 4 cycles, then FETCH; `regwrite` never asserted.
- beq with `zero`=1 → `pcen`=1 in BEQEX with `pcsrc`=01; repeated with `zero`=0 → `pcen`=0. blez with `zero`=1 → `aluop`=010, `pcen`=1.
- ori (001101) → IMMEX drives `aluop`=011, `zeroext`=1, `alusrcb`=10, then IMMWB `regwrite`=1; R-type → `alufunct`=1, then ALUWB `regdst`=1.
- op=111111 → `illegal`=1 for one cycle in DECODE, back to FETCH, no writes.
- Reset asserted during a FETCH stall and again during MEMWR → `memwrite`/`pcen`=0 in the reset cycle, and `state`=0 on the next cycle.

Source files
------------

// File: rtl/mc_controller_if.sv
// -----------------------------------------------------------------------------
// mc_controller_if
//
// Bundle of every signal exchanged between the multicycle MIPS control FSM
// and its datapath.
//
//   Datapath -> controller:
//     op[5:0]       opcode from the instruction register
//     zero          ALU condition flag (beq/blez condition met)
//     memready      memory access completes this cycle
//
//   Controller -> datapath:
//     pcen          PC write enable
//     iord          memory address select (0 = PC, 1 = ALUOut)
//     memwrite      memory write strobe
//     irwrite       instruction register load
//     regdst        register destination select (1 = rd, 0 = rt)
//     memtoreg      register write data select (1 = memory, 0 = ALUOut)
//     regwrite      register file write enable
//     alusrca       ALU A select (0 = PC, 1 = register A)
//     alusrcb[1:0]  ALU B select (00 B, 01 4, 10 imm, 11 imm<<2)
//     zeroext       zero-extend the immediate instead of sign-extending it
//     pcsrc[1:0]    next-PC select (00 ALU, 01 ALUOut, 10 jump target)
//     aluop[2:0]    ALU-op code for the ALU decoder
//     alufunct      ALU decoder takes the operation from the funct field
//     illegal       one-cycle pulse for an unsupported opcode
//     state[3:0]    current FSM state, for debug
//
// Modports:
//   master - the controller (drives the control outputs)
//   slave  - the datapath side (drives opcode, flag and memory ready)
// -----------------------------------------------------------------------------
interface mc_controller_if;
  logic [5:0] op;
  logic       zero;
  logic       memready;

  logic       pcen;
  logic       iord;
  logic       memwrite;
  logic       irwrite;
  logic       regdst;
  logic       memtoreg;
  logic       regwrite;
  logic       alusrca;
  logic [1:0] alusrcb;
  logic       zeroext;
  logic [1:0] pcsrc;
  logic [2:0] aluop;
  logic       alufunct;
  logic       illegal;
  logic [3:0] state;

  modport master (
    input  op,
    input  zero,
    input  memready,
    output pcen,
    output iord,
    output memwrite,
    output irwrite,
    output regdst,
    output memtoreg,
    output regwrite,
    output alusrca,
    output alusrcb,
    output zeroext,
    output pcsrc,
    output aluop,
    output alufunct,
    output illegal,
    output state
  );

  modport slave (
    output op,
    output zero,
    output memready,
    input  pcen,
    input  iord,
    input  memwrite,
    input  irwrite,
    input  regdst,
    input  memtoreg,
    input  regwrite,
    input  alusrca,
    input  alusrcb,
    input  zeroext,
    input  pcsrc,
    input  aluop,
    input  alufunct,
    input  illegal,
    input  state
  );
endinterface

// File: rtl/mc_controller.sv
// -----------------------------------------------------------------------------
// mc_controller
//
// Main control FSM of the multicycle MIPS datapath. Sequences fetch, decode,
// execute, memory and writeback over several cycles and drives every datapath
// mux select and write enable.
//
// Ports:
//   clk    - single clock, all state changes on the rising edge
//   reset  - synchronous, active-high; forces FETCH and blocks all writes
//   bus    - mc_controller_if.master, opcode/flags in, control signals out
//
// Memory handshake: the controller presents a memory access by sitting in
// FETCH, MEMRD or MEMWR with the address select and strobes held steady; the
// access is accepted in the cycle memready is 1 and the FSM advances on that
// edge. Any cycle with memready = 0 in those states repeats the state, so each
// stall cycle adds exactly one cycle. memready is ignored in all other states.
//
// All outputs are Moore decodes of the state register, except irwrite/pcwrite
// in FETCH (qualified by memready) and pcen (qualified by zero for branches).
// -----------------------------------------------------------------------------
module mc_controller (
  input  logic            clk,
  input  logic            reset,
  mc_controller_if.master bus
);

  // ---------------------------------------------------------------------------
  // State encoding (visible on bus.state)
  // ---------------------------------------------------------------------------
  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTYPEEX = 4'd6,
    S_ALUWB   = 4'd7,
    S_BEQEX   = 4'd8,
    S_IMMEX   = 4'd9,
    S_IMMWB   = 4'd10,
    S_JEX     = 4'd11,
    S_BLEZEX  = 4'd12
  } state_e;

  // Opcodes
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BLEZ  = 6'b000110;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  // ALU-op codes understood by the ALU decoder
  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_BLEZ = 3'b010;
  localparam logic [2:0] ALU_OR   = 3'b011;
  localparam logic [2:0] ALU_LUI  = 3'b100;
  localparam logic [2:0] ALU_XOR  = 3'b101;
  localparam logic [2:0] ALU_SLT  = 3'b110;
  localparam logic [2:0] ALU_AND  = 3'b111;

  // Mux select encodings
  localparam logic [1:0] SRCB_REG   = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  state_e state_q;
  state_e state_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and output decode
  // ---------------------------------------------------------------------------
  // Write enables are produced here unqualified and gated by reset below.
  logic       pcwrite;
  logic       branch;
  logic       memwrite_raw;
  logic       irwrite_raw;
  logic       regwrite_raw;
  logic       iord;
  logic       regdst;
  logic       memtoreg;
  logic       alusrca;
  logic [1:0] alusrcb;
  logic       zeroext;
  logic [1:0] pcsrc;
  logic [2:0] aluop;
  logic       alufunct;
  logic       illegal;

  always_comb begin
    state_d      = state_q;
    pcwrite      = 1'b0;
    branch       = 1'b0;
    memwrite_raw = 1'b0;
    irwrite_raw  = 1'b0;
    regwrite_raw = 1'b0;
    iord         = 1'b0;
    regdst       = 1'b0;
    memtoreg     = 1'b0;
    alusrca      = 1'b0;
    alusrcb      = SRCB_REG;
    zeroext      = 1'b0;
    pcsrc        = PCSRC_ALU;
    aluop        = ALU_ADD;
    alufunct     = 1'b0;
    illegal      = 1'b0;

    case (state_q)
      S_FETCH: begin
        // PC + 4 computed in the ALU; PC and IR load only when memory returns
        alusrcb     = SRCB_FOUR;
        aluop       = ALU_ADD;
        irwrite_raw = bus.memready;
        pcwrite     = bus.memready;
        if (bus.memready) begin
          state_d = S_DECODE;
        end
      end

      S_DECODE: begin
        // Speculatively compute the branch target into ALUOut
        alusrcb = SRCB_IMMSH;
        aluop   = ALU_ADD;
        case (bus.op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_RTYPEEX;
          OP_BEQ:       state_d = S_BEQEX;
          OP_BLEZ:      state_d = S_BLEZEX;
          OP_J:         state_d = S_JEX;
          OP_ADDI, OP_SLTI, OP_ANDI,
          OP_ORI, OP_XORI, OP_LUI:
                        state_d = S_IMMEX;
          default: begin
            state_d = S_FETCH;
            illegal = 1'b1;
          end
        endcase
      end

      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = SRCB_IMM;
        aluop   = ALU_ADD;
        // Only lw/sw reach this state, so anything other than sw is a load
        if (bus.op == OP_SW) begin
          state_d = S_MEMWR;
        end else begin
          state_d = S_MEMRD;
        end
      end

      S_MEMRD: begin
        iord = 1'b1;
        if (bus.memready) begin
          state_d = S_MEMWB;
        end
      end

      S_MEMWB: begin
        memtoreg     = 1'b1;
        regwrite_raw = 1'b1;
        state_d      = S_FETCH;
      end

      S_MEMWR: begin
        // Strobe held for the whole dwell so the memory sees a stable request
        iord         = 1'b1;
        memwrite_raw = 1'b1;
        if (bus.memready) begin
          state_d = S_FETCH;
        end
      end

      S_RTYPEEX: begin
        alusrca  = 1'b1;
        alusrcb  = SRCB_REG;
        alufunct = 1'b1;
        aluop    = ALU_ADD;
        state_d  = S_ALUWB;
      end

      S_ALUWB: begin
        regdst       = 1'b1;
        regwrite_raw = 1'b1;
        state_d      = S_FETCH;
      end

      S_BEQEX: begin
        alusrca = 1'b1;
        alusrcb = SRCB_REG;
        aluop   = ALU_SUB;
        pcsrc   = PCSRC_ALUOUT;
        branch  = 1'b1;
        state_d = S_FETCH;
      end

      S_BLEZEX: begin
        alusrca = 1'b1;
        alusrcb = SRCB_REG;
        aluop   = ALU_BLEZ;
        pcsrc   = PCSRC_ALUOUT;
        branch  = 1'b1;
        state_d = S_FETCH;
      end

      S_IMMEX: begin
        alusrca = 1'b1;
        alusrcb = SRCB_IMM;
        case (bus.op)
          OP_SLTI: aluop = ALU_SLT;
          OP_ANDI: begin
            aluop   = ALU_AND;
            zeroext = 1'b1;
          end
          OP_ORI: begin
            aluop   = ALU_OR;
            zeroext = 1'b1;
          end
          OP_XORI: begin
            aluop   = ALU_XOR;
            zeroext = 1'b1;
          end
          OP_LUI:  aluop = ALU_LUI;
          default: aluop = ALU_ADD;  // addi
        endcase
        state_d = S_IMMWB;
      end

      S_IMMWB: begin
        regwrite_raw = 1'b1;
        state_d      = S_FETCH;
      end

      S_JEX: begin
        pcsrc   = PCSRC_JUMP;
        pcwrite = 1'b1;
        state_d = S_FETCH;
      end

      default: begin
        // Unused encodings 13-15 recover to FETCH with all outputs idle
        state_d = S_FETCH;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs: write enables are blocked in any reset cycle, whatever the state
  // ---------------------------------------------------------------------------
  assign bus.pcen     = ~reset & (pcwrite | (branch & bus.zero));
  assign bus.memwrite = ~reset & memwrite_raw;
  assign bus.irwrite  = ~reset & irwrite_raw;
  assign bus.regwrite = ~reset & regwrite_raw;

  assign bus.iord     = iord;
  assign bus.regdst   = regdst;
  assign bus.memtoreg = memtoreg;
  assign bus.alusrca  = alusrca;
  assign bus.alusrcb  = alusrcb;
  assign bus.zeroext  = zeroext;
  assign bus.pcsrc    = pcsrc;
  assign bus.aluop    = aluop;
  assign bus.alufunct = alufunct;
  assign bus.illegal  = illegal;
  assign bus.state    = state_q;

endmodule

// File: tb/tb_mc_controller.sv
// -----------------------------------------------------------------------------
// tb_mc_controller
//
// Directed bench for mc_controller. Each cycle the driver applies reset/op/
// zero/memready, queues the hand-computed state and control vector, and the
// scoreboard compares them on the falling edge.
//
// Control vector layout (18 bits), grouped in the literals below as
//   {pcen,iord,memwrite,irwrite}_{regdst,memtoreg,regwrite,alusrca}
//   _{alusrcb}_{zeroext}_{pcsrc}_{aluop}_{alufunct,illegal}
// -----------------------------------------------------------------------------
module tb_mc_controller;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk;
  logic reset;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  mc_controller_if bus ();

  mc_controller dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  // Opcodes
  localparam logic [5:0] LW   = 6'b100011;
  localparam logic [5:0] SW   = 6'b101011;
  localparam logic [5:0] RTY  = 6'b000000;
  localparam logic [5:0] BEQ  = 6'b000100;
  localparam logic [5:0] BLEZ = 6'b000110;
  localparam logic [5:0] JMP  = 6'b000010;
  localparam logic [5:0] ADDI = 6'b001000;
  localparam logic [5:0] SLTI = 6'b001010;
  localparam logic [5:0] ORI  = 6'b001101;
  localparam logic [5:0] LUI  = 6'b001111;
  localparam logic [5:0] BAD  = 6'b111111;

  // Hand-computed control vectors
  localparam logic [17:0] C_FETCH   = 18'b1001_0000_01_0_00_000_00;
  localparam logic [17:0] C_FSTALL  = 18'b0000_0000_01_0_00_000_00;
  localparam logic [17:0] C_FRST    = 18'b0000_0000_01_0_00_000_00;
  localparam logic [17:0] C_DECODE  = 18'b0000_0000_11_0_00_000_00;
  localparam logic [17:0] C_DECILL  = 18'b0000_0000_11_0_00_000_01;
  localparam logic [17:0] C_MEMADR  = 18'b0000_0001_10_0_00_000_00;
  localparam logic [17:0] C_MEMRD   = 18'b0100_0000_00_0_00_000_00;
  localparam logic [17:0] C_MEMWB   = 18'b0000_0110_00_0_00_000_00;
  localparam logic [17:0] C_MEMWR   = 18'b0110_0000_00_0_00_000_00;
  localparam logic [17:0] C_MEMWRR  = 18'b0100_0000_00_0_00_000_00;
  localparam logic [17:0] C_RTYPE   = 18'b0000_0001_00_0_00_000_10;
  localparam logic [17:0] C_ALUWB   = 18'b0000_1010_00_0_00_000_00;
  localparam logic [17:0] C_BEQ_T   = 18'b1000_0001_00_0_01_001_00;
  localparam logic [17:0] C_BEQ_N   = 18'b0000_0001_00_0_01_001_00;
  localparam logic [17:0] C_BLEZ_T  = 18'b1000_0001_00_0_01_010_00;
  localparam logic [17:0] C_ORI     = 18'b0000_0001_10_1_00_011_00;
  localparam logic [17:0] C_SLTI    = 18'b0000_0001_10_0_00_110_00;
  localparam logic [17:0] C_LUI     = 18'b0000_0001_10_0_00_100_00;
  localparam logic [17:0] C_ADDI    = 18'b0000_0001_10_0_00_000_00;
  localparam logic [17:0] C_IMMWB   = 18'b0000_0010_00_0_00_000_00;
  localparam logic [17:0] C_JEX     = 18'b1000_0000_00_0_10_000_00;

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  logic [21:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end else begin
      n_pass++;
    end
  endtask

  function automatic logic [17:0] observed_ctl();
    return {bus.pcen, bus.iord, bus.memwrite, bus.irwrite,
            bus.regdst, bus.memtoreg, bus.regwrite, bus.alusrca,
            bus.alusrcb, bus.zeroext, bus.pcsrc, bus.aluop,
            bus.alufunct, bus.illegal};
  endfunction

  // ---------------------------------------------------------------------------
  // Driver: one clock cycle of stimulus plus its expectation
  // ---------------------------------------------------------------------------
  task automatic step(input string tag, input logic rst, input logic [5:0] o,
                      input logic z, input logic mr,
                      input logic [3:0] es, input logic [17:0] ec);
    logic [21:0] e;
    reset        = rst;
    bus.op       = o;
    bus.zero     = z;
    bus.memready = mr;
    exp_q.push_back({es, ec});
    @(negedge clk);
    e = exp_q.pop_front();
    check({tag, ".state"}, {28'd0, bus.state}, {28'd0, e[21:18]});
    check({tag, ".ctl"}, {14'd0, observed_ctl()}, {14'd0, e[17:0]});
    @(posedge clk);
    #1;
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    reset        = 1'b1;
    bus.op       = 6'd0;
    bus.zero     = 1'b0;
    bus.memready = 1'b1;
    @(posedge clk);
    #1;

    // Reset held with memready=1: FETCH but no writes
    step("rst",       1, LW,  0, 1, 4'd0,  C_FRST);

    // lw, no stalls: 0,1,2,3,4
    step("lw.fetch",  0, LW,  0, 1, 4'd0,  C_FETCH);
    step("lw.dec",    0, LW,  0, 1, 4'd1,  C_DECODE);
    step("lw.adr",    0, LW,  0, 1, 4'd2,  C_MEMADR);
    step("lw.rd",     0, LW,  0, 1, 4'd3,  C_MEMRD);
    step("lw.wb",     0, LW,  0, 1, 4'd4,  C_MEMWB);

    // sw with three stall cycles in MEMWR
    step("sw.fetch",  0, SW,  0, 1, 4'd0,  C_FETCH);
    step("sw.dec",    0, SW,  0, 1, 4'd1,  C_DECODE);
    step("sw.adr",    0, SW,  0, 1, 4'd2,  C_MEMADR);
    step("sw.wr0",    0, SW,  0, 0, 4'd5,  C_MEMWR);
    step("sw.wr1",    0, SW,  0, 0, 4'd5,  C_MEMWR);
    step("sw.wr2",    0, SW,  0, 0, 4'd5,  C_MEMWR);
    step("sw.wr3",    0, SW,  0, 1, 4'd5,  C_MEMWR);

    // beq taken, beq not taken, blez taken
    step("beqt.fetch", 0, BEQ, 1, 1, 4'd0,  C_FETCH);
    step("beqt.dec",   0, BEQ, 1, 1, 4'd1,  C_DECODE);
    step("beqt.ex",    0, BEQ, 1, 1, 4'd8,  C_BEQ_T);
    step("beqn.fetch", 0, BEQ, 0, 1, 4'd0,  C_FETCH);
    step("beqn.dec",   0, BEQ, 0, 1, 4'd1,  C_DECODE);
    step("beqn.ex",    0, BEQ, 0, 1, 4'd8,  C_BEQ_N);
    step("blez.fetch", 0, BLEZ, 1, 1, 4'd0, C_FETCH);
    step("blez.dec",   0, BLEZ, 1, 1, 4'd1, C_DECODE);
    step("blez.ex",    0, BLEZ, 1, 1, 4'd12, C_BLEZ_T);

    // ori, then R-type
    step("ori.fetch", 0, ORI, 0, 1, 4'd0,  C_FETCH);
    step("ori.dec",   0, ORI, 0, 1, 4'd1,  C_DECODE);
    step("ori.ex",    0, ORI, 0, 1, 4'd9,  C_ORI);
    step("ori.wb",    0, ORI, 0, 1, 4'd10, C_IMMWB);
    step("rty.fetch", 0, RTY, 0, 1, 4'd0,  C_FETCH);
    step("rty.dec",   0, RTY, 0, 1, 4'd1,  C_DECODE);
    step("rty.ex",    0, RTY, 0, 1, 4'd6,  C_RTYPE);
    step("rty.wb",    0, RTY, 0, 1, 4'd7,  C_ALUWB);

    // Unsupported opcode: illegal pulse, straight back to FETCH
    step("ill.fetch", 0, BAD, 0, 1, 4'd0,  C_FETCH);
    step("ill.dec",   0, BAD, 0, 1, 4'd1,  C_DECILL);

    // Jump (zero irrelevant)
    step("j.fetch",   0, JMP, 0, 1, 4'd0,  C_FETCH);
    step("j.dec",     0, JMP, 0, 1, 4'd1,  C_DECODE);
    step("j.ex",      0, JMP, 0, 1, 4'd11, C_JEX);

    // Reset during a FETCH stall
    step("fst.0",     0, SW,  0, 0, 4'd0,  C_FSTALL);
    step("fst.1",     0, SW,  0, 0, 4'd0,  C_FSTALL);
    step("fst.rst",   1, SW,  0, 1, 4'd0,  C_FRST);
    step("fst.after", 0, SW,  0, 1, 4'd0,  C_FETCH);

    // Reset during MEMWR
    step("wrr.dec",   0, SW,  0, 1, 4'd1,  C_DECODE);
    step("wrr.adr",   0, SW,  0, 1, 4'd2,  C_MEMADR);
    step("wrr.wr",    0, SW,  0, 0, 4'd5,  C_MEMWR);
    step("wrr.rst",   1, SW,  0, 0, 4'd5,  C_MEMWRR);
    step("wrr.after", 0, SLTI, 0, 1, 4'd0, C_FETCH);

    // slti, lui, addi immediate decodes
    step("slti.dec",  0, SLTI, 0, 1, 4'd1,  C_DECODE);
    step("slti.ex",   0, SLTI, 0, 1, 4'd9,  C_SLTI);
    step("slti.wb",   0, SLTI, 0, 1, 4'd10, C_IMMWB);
    step("lui.fetch", 0, LUI,  0, 1, 4'd0,  C_FETCH);
    step("lui.dec",   0, LUI,  0, 1, 4'd1,  C_DECODE);
    step("lui.ex",    0, LUI,  0, 1, 4'd9,  C_LUI);
    step("lui.wb",    0, LUI,  0, 1, 4'd10, C_IMMWB);
    step("addi.fetch", 0, ADDI, 0, 1, 4'd0, C_FETCH);
    step("addi.dec",  0, ADDI, 0, 1, 4'd1,  C_DECODE);
    step("addi.ex",   0, ADDI, 0, 1, 4'd9,  C_ADDI);
    step("addi.wb",   0, ADDI, 0, 1, 4'd10, C_IMMWB);

    // lw with one stall in MEMRD
    step("lws.fetch", 0, LW,  0, 1, 4'd0,  C_FETCH);
    step("lws.dec",   0, LW,  0, 1, 4'd1,  C_DECODE);
    step("lws.adr",   0, LW,  0, 1, 4'd2,  C_MEMADR);
    step("lws.rd0",   0, LW,  0, 0, 4'd3,  C_MEMRD);
    step("lws.rd1",   0, LW,  0, 1, 4'd3,  C_MEMRD);
    step("lws.wb",    0, LW,  0, 1, 4'd4,  C_MEMWB);
    step("lws.next",  0, LW,  0, 1, 4'd0,  C_FETCH);

    // Final report
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
